// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, signed types and the round/saturate helper for the FIR datapath
package fir_pkg;
  localparam int DATA_W = 16;
  localparam int COEF_W = 16;
  localparam int ACC_W = 40;
  localparam int OUT_W = 16;
  localparam int SHIFT = 15;
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef struct packed {
    logic sat;
    logic signed [63:0] val;
  } rs_t;
  function automatic rs_t round_sat(input logic signed [63:0] acc, input int shift, input int ow);
    logic signed [64:0] r, hi, lo;
    rs_t o;
    r = ($signed({acc[63], acc}) + (65'sd1 <<< (shift - 1))) >>> shift;
    hi = (65'sd1 <<< (ow - 1)) - 65'sd1;
    lo = -(65'sd1 <<< (ow - 1));
    o.sat = r > hi || r < lo;
    o.val = r > hi ? hi[63:0] : r < lo ? lo[63:0] : r[63:0];
    return o;
  endfunction
endpackage

// File: rtl/fir_round_sat.sv
// fir_round_sat: combinational round-half-up, arithmetic shift and saturate of an accumulator
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int ACC_W = fir_pkg::ACC_W,
  parameter int OUT_W = fir_pkg::OUT_W,
  parameter int SHIFT = fir_pkg::SHIFT
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    sat
);
  logic [63-OUT_W:0] unused_hi;
  assign {sat, unused_hi, out_data} = round_sat(64'(acc), SHIFT, OUT_W);
endmodule

// File: rtl/fir_mac.sv
// fir_mac: two-stage pipelined signed multiply-accumulate with rounded, saturated result
module fir_mac
  import fir_pkg::*;
#(
  parameter int DATA_W = fir_pkg::DATA_W,
  parameter int COEF_W = fir_pkg::COEF_W,
  parameter int ACC_W = fir_pkg::ACC_W,
  parameter int OUT_W = fir_pkg::OUT_W,
  parameter int SHIFT = fir_pkg::SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] sample,
  input  logic signed [COEF_W-1:0] coef,
  input  logic                     first,
  input  logic                     last,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic signed [ACC_W-1:0]  acc_full,
  output logic                     out_sat
);
  localparam int P_W = DATA_W + COEF_W;
  logic signed [P_W-1:0] p1;
  logic v1, f1, l1, rs_sat;
  logic signed [ACC_W-1:0] acc, acc_nx;
  logic signed [OUT_W-1:0] rd;
  assign acc_nx = f1 ? ACC_W'(p1) : acc + ACC_W'(p1);
  fir_round_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_rs (
    .acc(acc_nx),
    .out_data(rd),
    .sat(rs_sat)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      p1 <= '0;
      v1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      acc_full <= '0;
      out_sat <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        p1 <= P_W'(sample) * P_W'(coef);
        f1 <= first;
        l1 <= last;
      end
      if (v1) acc <= acc_nx;
      out_valid <= v1 && l1;
      if (v1 && l1) begin
        out_data <= rd;
        acc_full <= acc_nx;
        out_sat <= rs_sat;
      end
    end
  end
endmodule

// File: tb/tb_fir_mac.sv
// tb_fir_mac: table-driven and sequence checks of fir_mac against a scoreboard of expected results
module tb_fir_mac;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, first = 1'b0, last = 1'b0;
  logic signed [15:0] sample = '0, coef = '0;
  logic out_valid, out_sat;
  logic signed [15:0] out_data;
  logic signed [39:0] acc_full;
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic signed [39:0] acc;
    logic signed [15:0] od;
    logic sat;
  } exp_t;
  typedef struct {
    logic signed [15:0] s;
    logic signed [15:0] c;
    logic f;
    logic l;
    exp_t e;
  } vec_t;
  exp_t sb[$];
  exp_t got;
  vec_t tbl[$];
  fir_mac dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sample(sample), .coef(coef),
    .first(first), .last(last), .out_valid(out_valid), .out_data(out_data),
    .acc_full(acc_full), .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 64'sd1, 64'sd0);
      else begin
        got = sb.pop_front();
        chk("acc_full", 64'(acc_full), 64'(got.acc));
        chk("out_data", 64'(out_data), 64'(got.od));
        chk("out_sat", {63'd0, out_sat}, {63'd0, got.sat});
      end
    end
  end
  task automatic beat(input logic signed [15:0] s, input logic signed [15:0] c, input logic f, input logic l);
    in_valid = 1'b1;
    sample = s;
    coef = c;
    first = f;
    last = l;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      first = 1'b1;
      last = 1'b1;
      sample = 16'($urandom);
      coef = 16'($urandom);
      @(negedge clk);
    end
  endtask
  task automatic expect_out(input logic signed [39:0] a, input logic signed [15:0] o, input logic s);
    exp_t e;
    e.acc = a;
    e.od = o;
    e.sat = s;
    sb.push_back(e);
  endtask
  task automatic drain;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_pending", 64'(sb.size()), 64'sd0);
  endtask
  task automatic add(input logic signed [15:0] s, input logic signed [15:0] c, input logic f, input logic l,
                     input logic signed [39:0] a, input logic signed [15:0] o, input logic st);
    vec_t v;
    v.s = s; v.c = c; v.f = f; v.l = l;
    v.e.acc = a; v.e.od = o; v.e.sat = st;
    tbl.push_back(v);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    add(16'sh4000, 16'sh4000, 1, 1, 40'sd268435456, 16'sh2000, 0);
    add(-16'sd32768, -16'sd32768, 1, 1, 40'sd1073741824, 16'sh7FFF, 1);
    add(16'sd32767, -16'sd32768, 1, 1, -40'sd1073709056, -16'sd32767, 0);
    add(16'sd3, 16'sd5, 1, 1, 40'sd15, 16'sd0, 0);
    add(16'sd1, 16'sd16384, 1, 1, 40'sd16384, 16'sd1, 0);
    add(-16'sd1, 16'sd16384, 1, 1, -40'sd16384, 16'sd0, 0);
    add(-16'sd1, 16'sd16385, 1, 1, -40'sd16385, -16'sd1, 0);
    add(-16'sd32768, 16'sd32767, 1, 0, 40'sd0, 16'sd0, 0);
    add(-16'sd32768, 16'sd32767, 0, 1, -40'sd2147418112, -16'sd32768, 1);
    add(16'sd32767, 16'sd32767, 1, 0, 40'sd0, 16'sd0, 0);
    add(16'sd32767, 16'sd32767, 0, 1, 40'sd2147352578, 16'sd32767, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", {63'd0, out_valid}, 64'sd0);
    chk("reset_acc_full", 64'(acc_full), 64'sd0);
    chk("reset_out_data", 64'(out_data), 64'sd0);
    chk("reset_out_sat", {63'd0, out_sat}, 64'sd0);
    foreach (tbl[i]) begin
      if (tbl[i].l) expect_out(tbl[i].e.acc, tbl[i].e.od, tbl[i].e.sat);
      beat(tbl[i].s, tbl[i].c, tbl[i].f, tbl[i].l);
    end
    idle(1);
    drain();
    beat(16'sd1000, 16'sh7FFF, 1, 0);
    beat(-16'sd2000, 16'sh7FFF, 0, 0);
    idle(3);
    beat(16'sd3000, -16'sd32768, 0, 0);
    expect_out(-40'sd131075000, -16'sd4000, 0);
    beat(-16'sd4000, 16'sd1, 0, 1);
    idle(1);
    drain();
    idle(3);
    chk("hold_acc_full", 64'(acc_full), -64'sd131075000);
    chk("hold_out_data", 64'(out_data), -64'sd4000);
    expect_out(40'sd20000, 16'sd1, 0);
    beat(16'sd100, 16'sd200, 1, 1);
    expect_out(-40'sd120000, -16'sd4, 0);
    beat(-16'sd300, 16'sd400, 1, 1);
    chk("b2b_first_pulse", {63'd0, out_valid}, 64'sd1);
    idle(1);
    chk("b2b_second_pulse", {63'd0, out_valid}, 64'sd1);
    idle(1);
    chk("b2b_gap_after", {63'd0, out_valid}, 64'sd0);
    drain();
    beat(16'sd100, 16'sd100, 1, 0);
    beat(16'sd7, 16'sd7, 0, 0);
    expect_out(40'sd6, 16'sd0, 0);
    beat(16'sd2, 16'sd3, 1, 1);
    idle(1);
    drain();
    beat(16'sd5, 16'sd5, 1, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'sd0);
    chk("midrst_acc_full", 64'(acc_full), 64'sd0);
    chk("midrst_out_data", 64'(out_data), 64'sd0);
    chk("midrst_out_sat", {63'd0, out_sat}, 64'sd0);
    idle(1);
    chk("midrst_no_pulse", {63'd0, out_valid}, 64'sd0);
    expect_out(-40'sd49152, -16'sd1, 0);
    beat(-16'sd3, 16'sd16384, 0, 1);
    idle(1);
    drain();
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
